// File: rtl/dds_pkg.sv
// Shared constants for the DDS numerically controlled oscillator.
// Optional sine path is selected by the DDS_NCO_SIN_EN macro.
package dds_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_AMP     = 42;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real TWO_PI = 6.283185307179586;

  // Quarter-wave cosine entry, rounded half away from zero; the k=Q entry is pinned to 0.
  function automatic int quarter_cos(input int amp, input int addr_w, input int k);
    real x;
    int  res;
    if (k >= (1 << (addr_w - 2))) begin
      res = 0;
    end else begin
      x   = real'(amp) * $cos(TWO_PI * real'(k) / real'(1 << addr_w));
      res = $rtoi(x + 0.5);
    end
    return res;
  endfunction

endpackage

// File: rtl/quarter_wave_rom.sv
// Quarter-wave amplitude table with registered read, filled at elaboration.
// A second read port exists only when DDS_NCO_SIN_EN is defined.
module quarter_wave_rom
  import dds_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMP    = DEF_AMP
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic [ADDR_W-2:0] addr_a,
  output logic [DATA_W-1:0] data_a
`ifdef DDS_NCO_SIN_EN
  ,
  input  logic [ADDR_W-2:0] addr_b,
  output logic [DATA_W-1:0] data_b
`endif
);

  localparam int Q = 1 << (ADDR_W - 2);
  localparam logic [ADDR_W-2:0] Q_A = (ADDR_W - 1)'(Q);

  logic [DATA_W-1:0] rom_s [0:Q];
  logic [DATA_W-1:0] data_a_q;

  for (genvar k = 0; k <= Q; k++) begin : g_rom
    assign rom_s[k] = DATA_W'(quarter_cos(AMP, ADDR_W, k));
  end

  // Addresses above Q never occur from the mirror logic; they read as zero.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      data_a_q <= (addr_a > Q_A) ? '0 : rom_s[addr_a];
    end
  end

  assign data_a = data_a_q;

`ifdef DDS_NCO_SIN_EN
  logic [DATA_W-1:0] data_b_q;

  always_ff @(posedge clock) begin
    if (rd_en) begin
      data_b_q <= (addr_b > Q_A) ? '0 : rom_s[addr_b];
    end
  end

  assign data_b = data_b_q;
`endif

endmodule

// File: rtl/dds_nco.sv
// Three-stage DDS NCO: phase/index, quarter-table read, sign/mirror.
// Define DDS_NCO_SIN_EN to build the sine output; otherwise sin_out is 0.
module dds_nco
  import dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AMP     = DEF_AMP
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic [PHASE_W-1:0]        phase_off,
  output logic signed [DATA_W-1:0]  cos_out,
  output logic signed [DATA_W-1:0]  sin_out,
  output logic                      out_valid,
  output logic                      wrap
);

  localparam int RA_W = ADDR_W - 1;
  localparam logic [RA_W-1:0] Q_ADDR = RA_W'(1 << (ADDR_W - 2));

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [PHASE_W:0]   sum_s;
  logic [PHASE_W-1:0] phase_s;

  logic              v1_q, wrap1_q;
  logic [ADDR_W-1:0] idx1_q;
  quad_e             quad1_s;
  logic [RA_W-1:0]   r1_s, cos_addr_s;
  logic              cos_neg_s;

  logic              v2_q, cneg2_q, wrap2_q;
  logic [DATA_W-1:0] cos_mag_s;

  logic [DATA_W-1:0] cos_q;
  logic              out_valid_q, wrap_q;

  assign sum_s   = {1'b0, acc_q} + {1'b0, phase_inc};
  assign phase_s = acc_q + phase_off;

  // The carry kept beside acc marks that the current acc value came from an overflow.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (enable) begin
      acc_d   = sum_s[PHASE_W-1:0];
      carry_d = sum_s[PHASE_W];
    end else begin
      acc_d   = acc_q;
      carry_d = carry_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      v1_q    <= 1'b0;
      idx1_q  <= '0;
      wrap1_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      v1_q    <= enable;
      if (enable) begin
        idx1_q  <= phase_s[PHASE_W-1 -: ADDR_W];
        wrap1_q <= carry_q;
      end
    end
  end

  assign quad1_s = quad_e'(idx1_q[ADDR_W-1 -: 2]);
  assign r1_s    = RA_W'(idx1_q[ADDR_W-3:0]);

  always_comb begin
    cos_addr_s = r1_s;
    cos_neg_s  = 1'b0;
    case (quad1_s)
      QUAD_0:  begin cos_addr_s = r1_s;          cos_neg_s = 1'b0; end
      QUAD_1:  begin cos_addr_s = Q_ADDR - r1_s; cos_neg_s = 1'b1; end
      QUAD_2:  begin cos_addr_s = r1_s;          cos_neg_s = 1'b1; end
      QUAD_3:  begin cos_addr_s = Q_ADDR - r1_s; cos_neg_s = 1'b0; end
      default: begin cos_addr_s = r1_s;          cos_neg_s = 1'b0; end
    endcase
  end

`ifdef DDS_NCO_SIN_EN
  logic [RA_W-1:0]   sin_addr_s;
  logic              sin_neg_s, sneg2_q;
  logic [DATA_W-1:0] sin_mag_s, sin_q;

  // Sine is cosine one quadrant earlier: same table, rotated mirror/sign choice.
  always_comb begin
    sin_addr_s = Q_ADDR - r1_s;
    sin_neg_s  = 1'b0;
    case (quad1_s)
      QUAD_0:  begin sin_addr_s = Q_ADDR - r1_s; sin_neg_s = 1'b0; end
      QUAD_1:  begin sin_addr_s = r1_s;          sin_neg_s = 1'b0; end
      QUAD_2:  begin sin_addr_s = Q_ADDR - r1_s; sin_neg_s = 1'b1; end
      QUAD_3:  begin sin_addr_s = r1_s;          sin_neg_s = 1'b1; end
      default: begin sin_addr_s = Q_ADDR - r1_s; sin_neg_s = 1'b0; end
    endcase
  end
`endif

  quarter_wave_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .AMP    (AMP)
  ) u_rom (
    .clock  (clock),
    .rd_en  (v1_q),
    .addr_a (cos_addr_s),
    .data_a (cos_mag_s)
`ifdef DDS_NCO_SIN_EN
    ,
    .addr_b (sin_addr_s),
    .data_b (sin_mag_s)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      v2_q    <= 1'b0;
      cneg2_q <= 1'b0;
      wrap2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        cneg2_q <= cos_neg_s;
        wrap2_q <= wrap1_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cos_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      wrap_q      <= v2_q & wrap2_q;
      if (v2_q) begin
        cos_q <= cneg2_q ? ({DATA_W{1'b0}} - cos_mag_s) : cos_mag_s;
      end
    end
  end

`ifdef DDS_NCO_SIN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      sneg2_q <= 1'b0;
      sin_q   <= '0;
    end else begin
      if (v1_q) begin
        sneg2_q <= sin_neg_s;
      end
      if (v2_q) begin
        sin_q <= sneg2_q ? ({DATA_W{1'b0}} - sin_mag_s) : sin_mag_s;
      end
    end
  end

  assign sin_out = sin_q;
`else
  assign sin_out = '0;
`endif

  assign cos_out   = cos_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/dds_nco.md
DDS_NCO -- requirements
Module: dds_nco

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 8, full-cycle table index width (>=3, <=PHASE_W).
REQ-003 SHALL have parameter DATA_W, default 8, two's-complement output width.
REQ-004 SHALL have parameter AMP, default 42, peak amplitude (< 2^(DATA_W-1)).
REQ-005 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  advance accumulator and launch one sample this cycle.
REQ-008 SHALL have port clear  in  1  synchronous accumulator zero.
REQ-009 SHALL have port phase_inc  in  PHASE_W  per-sample phase step, unsigned.
REQ-010 SHALL have port phase_off  in  PHASE_W  phase offset added after the accumulator.
REQ-011 SHALL have port cos_out  out  DATA_W  signed cosine sample.
REQ-012 SHALL have port sin_out  out  DATA_W  signed sine sample.
REQ-013 SHALL have port out_valid  out  1  cos_out/sin_out hold a new sample.
REQ-014 SHALL have port wrap  out  1  sample's accumulator value came from an overflowing addition.

Function
REQ-015 Accumulator acc: when enable=1, acc <= acc + phase_inc (mod 2^PHASE_W); carry recorded; enable=0 holds acc.
REQ-016 Sample phase p = (acc + phase_off) mod 2^PHASE_W using acc before the update; index i = p[PHASE_W-1 -: ADDR_W] (truncation, no rounding).
REQ-017 Quarter table T[k], k=0..Q, Q=2^(ADDR_W-2): T[k] = round(AMP*cos(2*pi*k/2^ADDR_W)), half away from zero; T[Q]=0.
REQ-018 With quadrant q=i[ADDR_W-1:ADDR_W-2], r=low bits: cos = T[r], -T[Q-r], -T[r], T[Q-r] for q=0..3.
REQ-019 sin(i) SHALL equal cos((i - Q) mod 2^ADDR_W), using the same table.
REQ-020 Pipeline: 3 stages (phase/index, table read, sign/mirror); latency from enable to out_valid is exactly 3 cycles; throughput one sample per clock.
REQ-021 A stage register loads only when its valid bit is 1; cos_out/sin_out hold the last sample while out_valid=0.
REQ-022 wrap travels with its sample; asserted only together with out_valid.
REQ-023 clear=1 sets acc to 0 next cycle (overrides enable); samples already in flight complete unchanged.
REQ-024 Changes of phase_inc/phase_off take effect on the first enabled cycle they are present; no glitch samples.

Reset
REQ-025 reset=1 SHALL clear acc, all stage valid bits, out_valid=0, wrap=0, cos_out=0, sin_out=0 on the next edge.
REQ-026 Reset mid-stream SHALL discard all in-flight samples; reset dominates enable and clear.

Configuration
REQ-027 Macro DDS_NCO_SIN_EN: defined -> sine path per REQ-019 built.
REQ-028 Not defined -> no sine mirror logic or second table port; sin_out constant 0; cos path, latency and wrap unchanged.

Structure
REQ-029 Shared package dds_pkg SHALL hold default widths, AMP default and the quadrant encoding constants.
REQ-030 Sub-module quarter_wave_rom: Q+1 entries, registered read, contents generated at elaboration from AMP/ADDR_W/DATA_W; dual read port when DDS_NCO_SIN_EN.

Verification (defaults, DDS_NCO_SIN_EN defined)
REQ-031 reset, phase_inc=0x0100, enable=1 -> out_valid high from cycle 3; cos 0x2A,0x2A,...; sample 7 cos=0x29; sample 64 cos=0x00 sin=0x2A; sample 128 cos=0xD6.
REQ-032 phase_inc=0x4000 -> cos 0x2A,0x00,0xD6,0x00 repeating; sin 0x00,0x2A,0x00,0xD6; wrap on samples 4,8,...
REQ-033 phase_inc=0, phase_off=0x4000 -> cos=0x00, sin=0x2A constant; then phase_off=0x8000 -> cos=0xD6 three cycles later.
REQ-034 enable toggled 1,0,1,0 -> out_valid pattern identical, 3 cycles later; outputs held during gaps; accumulator advances twice.
REQ-035 reset asserted mid-stream with samples in flight -> out_valid=0 next cycle, no stale sample later; restart from cos=0x2A.
REQ-036 clear with enable=1 after 10 samples -> next launched sample has index 0 (cos=0x2A); in-flight samples unchanged.
